// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: paces FIFO-fed 2-bit QAM symbols onto the modulator
// with per-frame preamble insertion and delayed loopback error counting.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   enable              permits frame start and continuation
//   in_valid/in_data    symbol push into the FIFO, in_ready = not full
//   demod_in            symbol returned by the demodulator
//   mod_data            symbol driven to the modulator
//   mod_active          a frame (preamble or data) is on mod_data
//   sym_strobe          high on the first cycle of every symbol
//   fifo_level          current FIFO occupancy
//   check_count         saturating count of loopback comparisons
//   err_count           saturating count of loopback mismatches

module qam_symbol_scheduler #(
    parameter int SYMBOL_PERIOD = 8000,
    parameter int FIFO_DEPTH    = 8,
    parameter int PREAMBLE_LEN  = 4,
    parameter int CHECK_DELAY   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [1:0]                  in_data,
    output logic                        in_ready,
    input  logic [1:0]                  demod_in,
    output logic [1:0]                  mod_data,
    output logic                        mod_active,
    output logic                        sym_strobe,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 check_count,
    output logic [15:0]                 err_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HN = CHECK_DELAY + 1;

    localparam logic [15:0]   CNT_LAST = 16'(SYMBOL_PERIOD - 1);
    localparam logic [3:0]    PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    pre_q, pre_d;
    logic [1:0]    mod_q, mod_d;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;

    logic          push;
    logic          pop;
    logic          load;
    logic          clr_hist;
    logic          last;
    logic          empty;

    logic [1:0]    hist_sym [HN];
    logic          hist_vld [HN];
    logic          chk_en;
    logic          mism;
    logic [15:0]   chk_q, err_q;

    assign empty       = (lvl_q == '0);
    assign last        = (cnt_q == CNT_LAST);
    assign in_ready    = (lvl_q != FULL);
    assign push        = in_valid && in_ready;
    assign fifo_level  = lvl_q;
    assign mod_data    = mod_q;
    assign mod_active  = (state_q != IDLE);
    // The counter sits at 0 for every symbol's first cycle; with a
    // one-cycle period it never leaves 0, so the strobe stays high.
    assign sym_strobe  = mod_active && (cnt_q == 16'd0);
    assign check_count = chk_q;
    assign err_count   = err_q;

    // ---------------- symbol FIFO ----------------

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (push && !pop) begin
                lvl_q <= lvl_q + LW'(1);
            end else if (pop && !push) begin
                lvl_q <= lvl_q - LW'(1);
            end
        end
    end

    // ---------------- frame FSM ----------------

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            mod_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            mod_q   <= mod_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        mod_d    = mod_q;
        pop      = 1'b0;
        load     = 1'b0;
        clr_hist = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                mod_d = 2'b00;
                if (enable && !empty) begin
                    load = 1'b1;
                    if (PREAMBLE_LEN == 0) begin
                        state_d = DATA;
                        mod_d   = mem[rd_q];
                        pop     = 1'b1;
                    end else begin
                        state_d = PREAMBLE;
                        pre_d   = '0;
                        mod_d   = 2'b00;
                    end
                end
            end
            PREAMBLE: begin
                if (last) begin
                    cnt_d = '0;
                    load  = 1'b1;
                    // The FIFO was non-empty at frame start and nothing
                    // pops during the preamble, so a head symbol exists.
                    if (pre_q == PRE_LAST) begin
                        state_d = DATA;
                        mod_d   = mem[rd_q];
                        pop     = 1'b1;
                    end else begin
                        pre_d = pre_q + 4'd1;
                        // Next index is odd exactly when this one is even.
                        mod_d = pre_q[0] ? 2'b00 : 2'b11;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (last) begin
                    cnt_d = '0;
                    if (empty || !enable) begin
                        state_d  = IDLE;
                        mod_d    = 2'b00;
                        clr_hist = 1'b1;
                    end else begin
                        mod_d = mem[rd_q];
                        pop   = 1'b1;
                        load  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                mod_d   = 2'b00;
            end
        endcase
    end

    // ---------------- transmit history ----------------

    // Entry 0 is the symbol currently on mod_data; entry k is the symbol
    // sent k symbols earlier in the same frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < HN; i++) begin
                hist_sym[i] <= 2'b00;
                hist_vld[i] <= 1'b0;
            end
        end else if (clr_hist) begin
            for (int i = 0; i < HN; i++) begin
                hist_vld[i] <= 1'b0;
            end
        end else if (load) begin
            hist_sym[0] <= mod_d;
            hist_vld[0] <= 1'b1;
            for (int i = 1; i < HN; i++) begin
                hist_sym[i] <= hist_sym[i-1];
                hist_vld[i] <= hist_vld[i-1];
            end
        end
    end

    // ---------------- loopback checker ----------------

    assign chk_en = mod_active && last && hist_vld[CHECK_DELAY];
    assign mism   = (hist_sym[CHECK_DELAY] != demod_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_q <= '0;
            err_q <= '0;
        end else if (chk_en) begin
            if (chk_q != 16'hFFFF) begin
                chk_q <= chk_q + 16'd1;
            end
            if (mism && (err_q != 16'hFFFF)) begin
                err_q <= err_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb_qam_symbol_scheduler: table-driven, directed and randomized checks of
// qam_symbol_scheduler against expectations built inside the bench.

module tb_qam_symbol_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    // main instance: period 4, depth 4, preamble 2, delay 0
    logic       rst_a, en_a, v_a, rdy_a, act_a, stb_a;
    logic [1:0] d_a, dm_a, mod_a;
    logic [2:0] lvl_a;
    logic [15:0] chk_a, err_a;

    // randomized instance: period 3, depth 4, preamble 3, delay 2
    logic       rst_r, en_r, v_r, rdy_r, act_r, stb_r;
    logic [1:0] d_r, dm_r, mod_r;
    logic [2:0] lvl_r;
    logic [15:0] chk_r, err_r;

    // saturation instance: period 1, depth 4, preamble 2, delay 0
    logic       rst_s, en_s, v_s, rdy_s, act_s, stb_s;
    logic [1:0] d_s, dm_s, mod_s;
    logic [2:0] lvl_s;
    logic [15:0] chk_s, err_s;

    qam_symbol_scheduler #(
        .SYMBOL_PERIOD(4), .FIFO_DEPTH(4),
        .PREAMBLE_LEN(2), .CHECK_DELAY(0)
    ) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a),
        .in_valid(v_a), .in_data(d_a), .in_ready(rdy_a),
        .demod_in(dm_a), .mod_data(mod_a), .mod_active(act_a),
        .sym_strobe(stb_a), .fifo_level(lvl_a),
        .check_count(chk_a), .err_count(err_a)
    );

    qam_symbol_scheduler #(
        .SYMBOL_PERIOD(3), .FIFO_DEPTH(4),
        .PREAMBLE_LEN(3), .CHECK_DELAY(2)
    ) dut_r (
        .clk(clk), .rst(rst_r), .enable(en_r),
        .in_valid(v_r), .in_data(d_r), .in_ready(rdy_r),
        .demod_in(dm_r), .mod_data(mod_r), .mod_active(act_r),
        .sym_strobe(stb_r), .fifo_level(lvl_r),
        .check_count(chk_r), .err_count(err_r)
    );

    qam_symbol_scheduler #(
        .SYMBOL_PERIOD(1), .FIFO_DEPTH(4),
        .PREAMBLE_LEN(2), .CHECK_DELAY(0)
    ) dut_s (
        .clk(clk), .rst(rst_s), .enable(en_s),
        .in_valid(v_s), .in_data(d_s), .in_ready(rdy_s),
        .demod_in(dm_s), .mod_data(mod_s), .mod_active(act_s),
        .sym_strobe(stb_s), .fifo_level(lvl_s),
        .check_count(chk_s), .err_count(err_s)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- frame table ----------------

    typedef struct {
        logic       v;
        logic [1:0] d;
        logic [1:0] mod;
        logic       act;
        logic       stb;
        logic [2:0] lvl;
    } row_t;

    row_t tbl [19];

    function automatic row_t mk(input logic v, input logic [1:0] d,
                                input logic [1:0] mod, input logic act,
                                input logic stb, input logic [2:0] lvl);
        row_t r;
        r.v = v; r.d = d; r.mod = mod;
        r.act = act; r.stb = stb; r.lvl = lvl;
        return r;
    endfunction

    task automatic fill_table();
        tbl[0] = mk(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 3'd1);
        tbl[1] = mk(1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 3'd2);
        for (int i = 2; i <= 4; i++) tbl[i] = mk(0, 0, 2'b00, 1, 0, 3'd2);
        tbl[5] = mk(1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 3'd2);
        for (int i = 6; i <= 8; i++) tbl[i] = mk(0, 0, 2'b11, 1, 0, 3'd2);
        tbl[9] = mk(1'b0, 2'b00, 2'b01, 1'b1, 1'b1, 3'd1);
        for (int i = 10; i <= 12; i++) tbl[i] = mk(0, 0, 2'b01, 1, 0, 3'd1);
        tbl[13] = mk(1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 3'd0);
        for (int i = 14; i <= 16; i++) tbl[i] = mk(0, 0, 2'b10, 1, 0, 3'd0);
        for (int i = 17; i <= 18; i++) tbl[i] = mk(0, 0, 2'b00, 0, 0, 3'd0);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b0; en_a = 1'b0; v_a = 1'b0;
        d_a = 2'b00; dm_a = 2'b00;
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
    endtask

    task automatic run_table(input bit tie);
        logic [1:0] prev;
        prev = 2'b00;
        en_a = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            v_a  = tbl[i].v;
            d_a  = tbl[i].d;
            dm_a = tie ? prev : 2'b01;
            @(posedge clk);
            #1;
            chk($sformatf("frame row %0d", i),
                {mod_a, act_a, stb_a, lvl_a, rdy_a},
                {tbl[i].mod, tbl[i].act, tbl[i].stb, tbl[i].lvl,
                 tbl[i].lvl != 3'd4});
            prev = tbl[i].mod;
        end
        v_a = 1'b0;
    endtask

    // ---------------- frame capture ----------------

    logic [1:0] got [8];
    int         got_n;
    bit         got_ok;

    task automatic collect();
        got_n  = 0;
        got_ok = 1'b0;
        for (int k = 0; k < 8; k++) got[k] = 2'bxx;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (stb_a && got_n < 8) begin
                got[got_n] = mod_a;
                got_n++;
            end
            if (!act_a && got_n > 0) begin
                got_ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic expect_frame(input string tag, input int n_exp,
                                input logic [15:0] e);
        collect();
        chk({tag, " frame ended"}, got_ok, 1'b1);
        chk({tag, " symbol count"}, got_n, n_exp);
        for (int k = 0; k < n_exp; k++) begin
            chk($sformatf("%s sym%0d", tag, k), got[k], e[2*k +: 2]);
        end
    endtask

    // ---------------- reference model (randomized instance) ----------------

    localparam int RP  = 3;
    localparam int RD  = 4;
    localparam int RPL = 3;
    localparam int RCD = 2;

    logic [1:0] mq [$];
    logic [1:0] m_hist [$];
    bit         m_on;
    int         m_age;
    int         m_n;
    logic [1:0] m_cur;
    int         m_chk;
    int         m_err;

    task automatic m_send(input logic [1:0] s);
        m_cur = s;
        m_hist.push_back(s);
        m_n++;
        m_age = 0;
    endtask

    task automatic model_step(input bit en, input bit v,
                              input logic [1:0] d, input logic [1:0] dm);
        bit can_push;
        can_push = v && (mq.size() < RD);
        if (!m_on) begin
            if (en && mq.size() > 0) begin
                m_on = 1'b1;
                m_n  = 0;
                m_hist.delete();
                if (RPL > 0) m_send(2'b00);
                else         m_send(mq.pop_front());
            end
        end else if (m_age == RP - 1) begin
            if (m_n - 1 - RCD >= 0) begin
                if (m_chk < 65535) m_chk++;
                if (m_hist[m_n - 1 - RCD] != dm && m_err < 65535) m_err++;
            end
            if (m_n < RPL) begin
                m_send((m_n % 2 == 1) ? 2'b11 : 2'b00);
            end else if (m_n > RPL && (!en || mq.size() == 0)) begin
                m_on  = 1'b0;
                m_cur = 2'b00;
                m_age = 0;
            end else begin
                m_send(mq.pop_front());
            end
        end else begin
            m_age++;
        end
        if (can_push) mq.push_back(d);
    endtask

    // ---------------- test sequences ----------------

    task automatic directed();
        logic [9:0] sv;
        int         n;
        int         act_cnt;
        logic [1:0] third;
        bit         done;
        bit         seen;

        repeat (2) @(posedge clk);
        #1;
        chk("reset state",
            {mod_a, act_a, stb_a, lvl_a, rdy_a, chk_a, err_a},
            {2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0, 16'd0});

        // basic frame, demod looped back
        reset_a();
        run_table(1'b1);
        chk("loopback check_count", chk_a, 16'd4);
        chk("loopback err_count", err_a, 16'd0);

        // same frame, demod stuck at 01
        reset_a();
        run_table(1'b0);
        chk("stuck check_count", chk_a, 16'd4);
        chk("stuck err_count", err_a, 16'd3);

        // fill past full with enable low, then drain in order
        reset_a();
        sv = {2'b01, 2'b00, 2'b11, 2'b10, 2'b01};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            v_a = 1'b1;
            d_a = sv[2*k +: 2];
            @(posedge clk);
            #1;
            if (k == 3) begin
                chk("full ready low", rdy_a, 1'b0);
                chk("full level", lvl_a, 3'd4);
            end
        end
        v_a = 1'b0;
        chk("level after 5th push", lvl_a, 3'd4);
        en_a = 1'b1;
        expect_frame("full drain", 6,
                     {4'b0, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00});
        chk("full drained level", lvl_a, 3'd0);

        // enable dropped during first data symbol
        reset_a();
        sv = {4'b0, 2'b11, 2'b10, 2'b01};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v_a = 1'b1;
            d_a = sv[2*k +: 2];
        end
        @(negedge clk);
        v_a  = 1'b0;
        en_a = 1'b1;
        n = 0; third = 2'b00; done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (stb_a) begin
                n++;
                if (n == 3) begin
                    third = mod_a;
                    en_a  = 1'b0;
                end
            end
            if (!act_a && n > 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drop enable ended", done, 1'b1);
        chk("drop enable strobes", n, 3);
        chk("drop enable data sym", third, 2'b01);
        chk("drop enable level", lvl_a, 3'd2);

        // reset mid-preamble with two symbols still queued
        en_a = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (act_a) begin
                seen = 1'b1;
                break;
            end
        end
        chk("restart frame started", seen, 1'b1);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        #1;
        chk("async reset outputs",
            {mod_a, act_a, stb_a, lvl_a, rdy_a, chk_a, err_a},
            {2'b00, 1'b0, 1'b0, 3'd0, 1'b1, 16'd0, 16'd0});
        @(negedge clk);
        rst_a = 1'b1;
        act_cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (act_a) act_cnt++;
        end
        chk("idle after reset", act_cnt, 0);
        chk("level after reset", lvl_a, 3'd0);
        @(negedge clk);
        v_a = 1'b1;
        d_a = 2'b10;
        @(negedge clk);
        v_a = 1'b0;
        expect_frame("post reset", 3, {10'b0, 2'b10, 2'b11, 2'b00});
    endtask

    task automatic random_run();
        @(negedge clk);
        rst_r = 1'b0; en_r = 1'b0; v_r = 1'b0;
        repeat (2) @(negedge clk);
        rst_r = 1'b1;
        mq.delete(); m_hist.delete();
        m_on = 1'b0; m_age = 0; m_n = 0; m_cur = 2'b00;
        m_chk = 0; m_err = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            v_r  = (c < 1500) ? ($urandom_range(0, 3) == 0)
                              : ($urandom_range(0, 3) != 0);
            d_r  = 2'($urandom_range(0, 3));
            dm_r = 2'($urandom_range(0, 3));
            en_r = ($urandom_range(0, 15) != 0);
            @(posedge clk);
            model_step(en_r, v_r, d_r, dm_r);
            #1;
            chk($sformatf("rand cycle %0d", c),
                {mod_r, act_r, stb_r, lvl_r, rdy_r, chk_r, err_r},
                {m_on ? m_cur : 2'b00, m_on, m_on && (m_age == 0),
                 3'(mq.size()), mq.size() < RD,
                 16'(m_chk), 16'(m_err)});
        end
    endtask

    // Every active cycle ends a symbol and every symbol mismatches 01,
    // so after edge k (k >= 3) both counters equal k-2 until saturation.
    task automatic sat_run();
        repeat (2) @(negedge clk);
        rst_s = 1'b1;
        v_s   = 1'b1;
        for (int k = 1; k <= 65610; k++) begin
            @(posedge clk);
            if (k == 1002 || k == 65537 || k == 65610) begin
                #1;
                chk($sformatf("sat err at edge %0d", k), err_s,
                    (k == 1002) ? 16'd1000 : 16'hFFFF);
                chk($sformatf("sat checks at edge %0d", k), chk_s,
                    (k == 1002) ? 16'd1000 : 16'hFFFF);
                chk($sformatf("sat strobe at edge %0d", k),
                    {act_s, stb_s}, 2'b11);
            end
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b0; en_a = 1'b0; v_a = 1'b0; d_a = 2'b00; dm_a = 2'b00;
        rst_r = 1'b0; en_r = 1'b0; v_r = 1'b0; d_r = 2'b00; dm_r = 2'b00;
        rst_s = 1'b0; en_s = 1'b1; v_s = 1'b0; d_s = 2'b10; dm_s = 2'b01;
        fill_table();
        fork
            begin
                directed();
                random_run();
            end
            sat_run();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
